// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU operand sequencer and the ALU it feeds.
// State encodings double as the LEDG stage display.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        S_LOAD_A  = 3'd0,
        S_LOAD_B  = 3'd1,
        S_LOAD_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SHOW    = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_DEC = 3'b010;
    localparam logic [2:0] OP_INC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;

endpackage

// File: rtl/alu_operand_seq_key.sv
// Pushbutton conditioning: 2-FF sync, optional debounce, falling-edge pulse.
// Debounce filter is built only when ALU_SEQ_DEBOUNCE_EN is defined.
module key_press_pulse #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          filt;

    // Count consecutive samples that disagree with the filtered level.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt  <= '0;
            filt <= 1'b1;
        end else if (sync2 == filt) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            filt <= sync2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level;
        end
    end

    assign press = level_q & ~level;

endmodule

// File: rtl/alu_operand_seq.sv
// Loads A, B and opcode from switches, fires the ALU, holds the result.
// Build option: ALU_SEQ_DEBOUNCE_EN enables the key debounce filter.
module alu_operand_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int OPW             = 3,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_data,
    input  logic             key_next_n,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_ovf,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [OPW-1:0]   opcode,
    output logic             op_valid,
    output logic [WIDTH-1:0] result,
    output logic             result_ovf,
    output logic [2:0]       stage
);

    state_t state;
    logic   press;

    key_press_pulse #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk    (CLOCK_50),
        .reset_n(reset_n),
        .key_n  (key_next_n),
        .press  (press)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state      <= S_LOAD_A;
            op_a       <= '0;
            op_b       <= '0;
            opcode     <= '0;
            op_valid   <= 1'b0;
            result     <= '0;
            result_ovf <= 1'b0;
        end else begin
            op_valid <= 1'b0;
            case (state)
                S_LOAD_A: begin
                    if (press) begin
                        op_a  <= sw_data;
                        state <= S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    if (press) begin
                        op_b  <= sw_data;
                        state <= S_LOAD_OP;
                    end
                end
                S_LOAD_OP: begin
                    if (press) begin
                        opcode   <= sw_data[OPW-1:0];
                        op_valid <= 1'b1;
                        state    <= S_EXEC;
                    end
                end
                // Any press arriving here is dropped.
                S_EXEC: begin
                    result     <= alu_result;
                    result_ovf <= alu_ovf;
                    state      <= S_SHOW;
                end
                S_SHOW: begin
                    if (press) begin
                        state <= S_LOAD_A;
                    end
                end
                default: begin
                    state <= S_LOAD_A;
                end
            endcase
        end
    end

    assign stage = state;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Directed bench for alu_operand_seq with a behavioural ALU model.
// Works with ALU_SEQ_DEBOUNCE_EN defined or not (DEBOUNCE_CYCLES=4).
module tb_alu_operand_seq;
    import alu_seq_pkg::*;

    localparam int DB = 4;
`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int LAT = DB + 3;
`else
    localparam int LAT = 3;
`endif

    logic       clk;
    logic       reset_n;
    logic [7:0] sw_data;
    logic       key_n;
    logic [7:0] alu_result;
    logic       alu_ovf;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [2:0] opcode;
    logic       op_valid;
    logic [7:0] result;
    logic       result_ovf;
    logic [2:0] stage;

    int vectors;
    int miscompares;
    int nvalid;
    int nv0;

    alu_operand_seq #(
        .WIDTH(8),
        .OPW(3),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .CLOCK_50  (clk),
        .reset_n   (reset_n),
        .sw_data   (sw_data),
        .key_next_n(key_n),
        .alu_result(alu_result),
        .alu_ovf   (alu_ovf),
        .op_a      (op_a),
        .op_b      (op_b),
        .opcode    (opcode),
        .op_valid  (op_valid),
        .result    (result),
        .result_ovf(result_ovf),
        .stage     (stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_result = 8'h00;
        alu_ovf    = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_result = op_a + op_b;
                alu_ovf = (op_a[7] == op_b[7]) && (alu_result[7] != op_a[7]);
            end
            OP_SUB: begin
                alu_result = op_a - op_b;
                alu_ovf = (op_a[7] != op_b[7]) && (alu_result[7] != op_a[7]);
            end
            OP_DEC: begin
                alu_result = op_a - 8'h01;
                alu_ovf = (op_a == 8'h80);
            end
            OP_INC: begin
                alu_result = op_a + 8'h01;
                alu_ovf = (op_a == 8'h7F);
            end
            OP_AND: alu_result = op_a & op_b;
            OP_OR:  alu_result = op_a | op_b;
            OP_NOT: alu_result = ~op_a;
            default: alu_result = 8'h00;
        endcase
    end

    always @(negedge clk) begin
        if (op_valid === 1'b1) nvalid++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [7:0] v);
        @(posedge clk);
        #1;
        sw_data = v;
        key_n = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        #1;
        key_n = 1'b1;
        repeat (LAT + 3) @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        nvalid = 0;
        reset_n = 1'b0;
        key_n = 1'b1;
        sw_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stage", stage, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_valid", op_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", result_ovf, 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

`ifdef ALU_SEQ_DEBOUNCE_EN
        sw_data = 8'h33;
        key_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        key_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("glitch_stage", stage, 0);
        chk("glitch_op_a", op_a, 0);
`endif

        @(posedge clk);
        #1;
        sw_data = 8'h05;
        key_n = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1;
        chk("lat_early_stage", stage, 0);
        @(posedge clk);
        #1;
        chk("lat_stage", stage, 1);
        chk("lat_op_a", op_a, 8'h05);
        repeat (20 - LAT) @(posedge clk);
        #1;
        chk("held_stage", stage, 1);
        key_n = 1'b1;
        repeat (LAT + 3) @(posedge clk);
        #1;

        press(8'h03);
        chk("b_stage", stage, 2);
        chk("b_op_b", op_b, 8'h03);

        nv0 = nvalid;
        @(posedge clk);
        #1;
        sw_data = 8'h00;
        key_n = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        chk("exec_stage", stage, 3);
        chk("exec_valid", op_valid, 1);
        chk("exec_result_old", result, 0);
        @(posedge clk);
        #1;
        chk("show_stage", stage, 4);
        chk("show_valid", op_valid, 0);
        chk("add_result", result, 8'h08);
        chk("add_ovf", result_ovf, 0);
        key_n = 1'b1;
        repeat (LAT + 3) @(posedge clk);
        #1;
        chk("valid_count", nvalid - nv0, 1);
        chk("show_hold_stage", stage, 4);
        chk("keep_op_a", op_a, 8'h05);

        press(8'h99);
        chk("show_to_a", stage, 0);
        chk("show_to_a_res", result, 8'h08);
        press(8'h10);
        chk("reload_stage", stage, 1);
        chk("reload_op_a", op_a, 8'h10);
        chk("reload_res", result, 8'h08);
        chk("reload_op_b", op_b, 8'h03);

        press(8'h7F);
        press(8'hFE);
        chk("not_opcode", opcode, 3'b110);
        chk("not_stage", stage, 4);
        chk("not_result", result, 8'hEF);
        chk("not_ovf", result_ovf, 0);

        press(8'h00);
        press(8'h7F);
        press(8'h01);
        press(8'hF8);
        chk("ovf_result", result, 8'h80);
        chk("ovf_flag", result_ovf, 1);

        press(8'h00);
        press(8'hAA);
        press(8'h55);
        chk("pre_rst_stage", stage, 2);
        chk("pre_rst_op_a", op_a, 8'hAA);
        nv0 = nvalid;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_stage", stage, 0);
        chk("mid_rst_op_a", op_a, 0);
        chk("mid_rst_op_b", op_b, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_ovf", result_ovf, 0);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_novalid", nvalid - nv0, 0);
        chk("mid_rst_idle", stage, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
